// File: rtl/lgn_argmax_stream.sv
// Streaming popcount arg-max scorer; LGN_ARGMAX_MARGIN_EN adds best-minus-runner-up margin output.
// Latency: result valid 1 cycle after the final beat of a frame is accepted.
// Backpressure: in_ready drops while a result waits; result held until out_ready, clear discards it.
module lgn_argmax_stream #(
    parameter  int CATEGORIES        = 10,
    parameter  int BITS_PER_CATEGORY = 255,
    parameter  int CHUNK_W           = 64,
    localparam int BEATS             = (BITS_PER_CATEGORY + CHUNK_W - 1) / CHUNK_W,
    localparam int SUM_W             = $clog2(BITS_PER_CATEGORY + 1),
    localparam int IDX_W             = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] in_bits,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [SUM_W-1:0]   out_value,
    output logic [SUM_W-1:0]   out_margin
);

    localparam int BCNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_BITS = BITS_PER_CATEGORY - (BEATS - 1) * CHUNK_W;
    localparam logic [CHUNK_W-1:0] LAST_MASK = {CHUNK_W{1'b1}} >> (CHUNK_W - LAST_BITS);

    typedef enum logic {ST_ACCUM, ST_OUTPUT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCNT_W-1:0]  r_beat;
    logic [IDX_W-1:0]   r_cat;
    logic [SUM_W-1:0]   r_acc;
    logic [SUM_W-1:0]   r_best;
    logic [IDX_W-1:0]   r_best_idx;
    logic [IDX_W-1:0]   r_out_index;
    logic [SUM_W-1:0]   r_out_value;

    logic               w_accept;
    logic               w_last_beat;
    logic               w_last_cat;
    logic [CHUNK_W-1:0] w_masked;
    logic [SUM_W-1:0]   w_pop;
    logic [SUM_W-1:0]   w_cand;
    logic               w_take;
    logic [SUM_W-1:0]   w_best_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;

    assign w_accept    = (r_state == ST_ACCUM) && in_valid && !clear;
    assign w_last_beat = (r_beat == BCNT_W'(BEATS - 1));
    assign w_last_cat  = (r_cat == IDX_W'(CATEGORIES - 1));
    assign w_masked    = w_last_beat ? (in_bits & LAST_MASK) : in_bits;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            w_pop = w_pop + SUM_W'(w_masked[i]);
        end
    end

    // Strict compare keeps ties on the lowest category index.
    assign w_cand     = r_acc + w_pop;
    assign w_take     = (r_cat == '0) || (w_cand > r_best);
    assign w_best_nxt = w_take ? w_cand : r_best;
    assign w_idx_nxt  = w_take ? r_cat : r_best_idx;

`ifdef LGN_ARGMAX_MARGIN_EN
    logic [SUM_W-1:0] r_second;
    logic [SUM_W-1:0] w_second_nxt;
    logic [SUM_W-1:0] r_out_margin;

    always_comb begin
        w_second_nxt = r_second;
        if (r_cat == '0) begin
            w_second_nxt = '0;
        end else if (w_cand > r_best) begin
            w_second_nxt = r_best;
        end else if (w_cand > r_second) begin
            w_second_nxt = w_cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_second     <= '0;
            r_out_margin <= '0;
        end else if (clear || (r_state == ST_OUTPUT && out_ready)) begin
            r_second <= '0;
        end else if (w_accept && w_last_beat) begin
            if (w_last_cat) begin
                r_second     <= '0;
                r_out_margin <= w_best_nxt - w_second_nxt;
            end else begin
                r_second <= w_second_nxt;
            end
        end
    end

    assign out_margin = r_out_margin;
`else
    assign out_margin = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_last_beat && w_last_cat) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
        if (clear) begin
            w_state_nxt = ST_ACCUM;
        end
    end

    // Trackers are zeroed as the frame closes so the next frame starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat      <= '0;
            r_cat       <= '0;
            r_acc       <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_out_index <= '0;
            r_out_value <= '0;
        end else if (clear || (r_state == ST_OUTPUT && out_ready)) begin
            r_beat     <= '0;
            r_cat      <= '0;
            r_acc      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
        end else if (w_accept) begin
            if (w_last_beat) begin
                r_beat <= '0;
                r_acc  <= '0;
                if (w_last_cat) begin
                    r_cat       <= '0;
                    r_best      <= '0;
                    r_best_idx  <= '0;
                    r_out_index <= w_idx_nxt;
                    r_out_value <= w_best_nxt;
                end else begin
                    r_cat      <= r_cat + IDX_W'(1);
                    r_best     <= w_best_nxt;
                    r_best_idx <= w_idx_nxt;
                end
            end else begin
                r_beat <= r_beat + BCNT_W'(1);
                r_acc  <= w_cand;
            end
        end
    end

    assign out_index = r_out_index;
    assign out_value = r_out_value;

endmodule

// File: tb/tb_lgn_argmax_stream.sv
// Randomised and directed bench for lgn_argmax_stream against a frame-level scoring model.
module tb_lgn_argmax_stream;

    localparam int CATS  = 10;
    localparam int BPC   = 255;
    localparam int CW    = 64;
    localparam int BEATS = 4;
`ifdef LGN_ARGMAX_MARGIN_EN
    localparam bit MARGIN_ON = 1'b1;
`else
    localparam bit MARGIN_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_bits;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_index;
    logic [7:0]    out_value;
    logic [7:0]    out_margin;

    always #5 clk = ~clk;

    lgn_argmax_stream #(
        .CATEGORIES(CATS), .BITS_PER_CATEGORY(BPC), .CHUNK_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_value(out_value), .out_margin(out_margin)
    );

    typedef struct {
        int idx;
        int val;
        int mar;
    } exp_t;

    int tests = 0;
    int fails = 0;
    int pushed = 0;
    int handshakes = 0;
    int rdy_mode = 2;
    logic [BEATS*CW-1:0] fr [CATS];
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    // Scores are plain bit counts of each category's valid bits; ties go to the lowest index.
    function automatic void model(output int idx, output int val, output int mar);
        int sc[CATS];
        int sec;
        for (int c = 0; c < CATS; c++) sc[c] = $countones(fr[c][BPC-1:0]);
        idx = 0;
        for (int c = 1; c < CATS; c++) if (sc[c] > sc[idx]) idx = c;
        val = sc[idx];
        sec = 0;
        for (int c = 0; c < CATS; c++) if (c != idx && sc[c] > sec) sec = sc[c];
        mar = MARGIN_ON ? (val - sec) : 0;
    endfunction

    task automatic clear_frame();
        for (int c = 0; c < CATS; c++) fr[c] = '0;
    endtask

    // Bit 255 lies beyond the category width and gets random junk to exercise masking.
    task automatic set_score(input int c, input int k);
        fr[c] = '0;
        for (int i = 0; i < k; i++) fr[c][i] = 1'b1;
        fr[c][BEATS*CW-1] = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_frame();
        int shared;
        shared = $urandom_range(0, BPC);
        for (int c = 0; c < CATS; c++) begin
            case ($urandom_range(0, 4))
                0: fr[c] = '0;
                1: fr[c] = '1;
                2: for (int w = 0; w < BEATS*CW/32; w++) fr[c][w*32 +: 32] = $urandom;
                3: set_score(c, shared);
                default: set_score(c, $urandom_range(0, BPC));
            endcase
        end
    endtask

    task automatic pin(input string nm, input int idx, input int val, input int mar);
        int mi, mv, mm;
        model(mi, mv, mm);
        chk({nm, "_model_idx"}, mi, idx);
        chk({nm, "_model_val"}, mv, val);
        chk({nm, "_model_margin"}, mm, MARGIN_ON ? mar : 0);
    endtask

    task automatic send_beat(input logic [CW-1:0] b, input int gapmax);
        int t;
        t = 0;
        in_valid = 1'b0;
        in_bits  = CW'({$urandom, $urandom});
        repeat ($urandom_range(0, gapmax)) @(negedge clk);
        in_valid = 1'b1;
        in_bits  = b;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL beat_accept_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit push, input int gapmax);
        exp_t e;
        if (push) begin
            model(e.idx, e.val, e.mar);
            exp_q.push_back(e);
            pushed++;
        end
        for (int c = 0; c < CATS; c++)
            for (int b = 0; b < BEATS; b++)
                send_beat(fr[c][b*CW +: CW], gapmax);
        chk("latency_out_valid", out_valid, 1);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_beat(fr[i/BEATS][(i%BEATS)*CW +: CW], 0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                chk("in_ready_low_while_output", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got index %0d value %0d, expected none", out_index, out_value);
                    end else begin
                        e = exp_q.pop_front();
                        handshakes++;
                        chk("out_index", out_index, e.idx);
                        chk("out_value", out_value, e.val);
                        chk("out_margin", out_margin, e.mar);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ei, ev, em, t;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_index", out_index, 0);
        chk("reset_out_value", out_value, 0);
        chk("reset_out_margin", out_margin, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        clear_frame(); fr[3] = '1;
        pin("cat3_ones", 3, 255, 255);
        send_frame(1, 0);

        clear_frame(); fr[0][BEATS*CW-1 -: CW] = '1;
        pin("cat0_last_mask", 0, 63, 63);
        send_frame(1, 1);

        for (int c = 0; c < CATS; c++) set_score(c, 40);
        set_score(2, 100); set_score(7, 100);
        pin("tie_2_7", 2, 100, 0);
        send_frame(1, 1);

        clear_frame(); set_score(9, 200); set_score(4, 150);
        pin("cat9_over_4", 9, 200, 50);
        send_frame(1, 0);
        wait_drain();

        clear_frame(); set_score(6, 77); set_score(1, 30);
        model(ei, ev, em);
        rdy_mode = 1;
        send_frame(1, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_index", out_index, ei);
            chk("bp_out_value", out_value, ev);
            chk("bp_out_margin", out_margin, em);
            chk("bp_in_ready", in_ready, 0);
        end
        rdy_mode = 2;
        t = 0;
        while (out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("release_in_ready", in_ready, 1);
        rand_frame();
        send_frame(1, 2);
        wait_drain();

        rand_frame();
        send_partial(17);
        clear = 1'b1; in_valid = 1'b1; in_bits = '1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_out_valid", out_valid, 0);
        chk("clear_in_ready", in_ready, 1);
        clear_frame(); set_score(5, 10);
        pin("after_clear", 5, 10, 10);
        send_frame(1, 0);
        wait_drain();

        rand_frame();
        send_partial(17);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_index", out_index, 0);
        chk("midrst_out_value", out_value, 0);
        chk("midrst_out_margin", out_margin, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_frame(); set_score(5, 10);
        send_frame(1, 0);
        wait_drain();

        rdy_mode = 1;
        rand_frame();
        send_frame(0, 0);
        repeat (2) @(negedge clk);
        chk("pending_out_valid", out_valid, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_output_valid", out_valid, 0);
        chk("clear_output_in_ready", in_ready, 1);
        rdy_mode = 2;
        @(negedge clk);

        rdy_mode = 0;
        repeat (30) begin
            rand_frame();
            send_frame(1, 2);
        end
        rdy_mode = 2;
        wait_drain();
        chk("result_count", handshakes, pushed);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lgn_argmax_stream.md
Name: lgn_argmax_stream

Overview:
- Sequential successor to the combinational 10-way popcount plus arg-max scorer at the output of the logic-gate network.
- Accepts category output bits as a stream of CHUNK_W-bit beats over a valid/ready handshake.
- Accumulates a per-category popcount and tracks the running best category.
- Presents the winning index and score over a valid/ready output handshake.
- Category count, bits per category and chunk width are all parameters, so wide nets can be scored with much less area than a full parallel popcount tree.

Parameters:
- CATEGORIES, 10, number of classes per frame.
- BITS_PER_CATEGORY, 255, output bits per class.
- CHUNK_W, 64, bits per input beat.
- BEATS, derived: ceil(BITS_PER_CATEGORY/CHUNK_W), beats per category.
- SUM_W, derived: $clog2(BITS_PER_CATEGORY+1), score width.
- IDX_W, derived: $clog2(CATEGORIES), index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous frame abort
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid and in_ready are both high
- in_bits  in  CHUNK_W  category bits; bit 0 is the lowest category bit of this beat
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid and out_ready are both high
- out_index  out  IDX_W  winning category
- out_value  out  SUM_W  winning score
- out_margin  out  SUM_W  best score minus second-best score (see Optional Feature)

Behaviour:
- One clock domain. Reset is asynchronous, active-low.
- Reset values:
  - out_valid=0, out_index=0, out_value=0, out_margin=0.
  - Internal beat counter, category counter, accumulator, best and second registers all 0.
  - State ACCUM.
- Frame order: category 0 beats 0..BEATS-1, then category 1, and so on. Total CATEGORIES*BEATS beats per frame.
- Last beat of each category: only the low BITS_PER_CATEGORY-(BEATS-1)*CHUNK_W bits count; higher bits are masked to 0. No mask applies when the division is exact.
- Popcount of the masked beat is added into a SUM_W accumulator. No overflow is possible by construction.
- Category close (its last beat accepted):
  - cand = acc + popcount(beat), computed in the same cycle.
  - If cat==0, or cand is strictly greater than best, then best <= cand and best_idx <= cat. Ties therefore go to the lowest index.
  - acc is cleared.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - When the final beat of the frame is accepted, go to OUTPUT.
  - Next cycle: out_valid=1 and out_index/out_value hold the result. Latency is 1 cycle after the final beat.
- State OUTPUT:
  - in_ready=0.
  - out_* held stable while out_valid=1 and out_ready=0.
  - When out_ready=1, go to ACCUM next cycle with all counters and trackers zeroed. A new frame's first beat is accepted in that cycle.
  - No bubble beyond this 1 cycle.
- clear=1 in any state:
  - Next state ACCUM, counters, accumulator and trackers zeroed, out_valid=0.
  - A beat presented in the same cycle is dropped (clear wins).
  - clear during OUTPUT discards the pending result.
- in_valid=0 in ACCUM: no state change. Gaps between beats are unrestricted.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is lost.
- CATEGORIES=1: out_index=0, out_value equals that category's popcount.

Optional Feature:
- Macro: LGN_ARGMAX_MARGIN_EN.
- Defined:
  - A second-best register tracks the runner-up score.
  - On category close with cand > best: second <= best (cat 0 sets second=0).
  - Else if cand > second: second <= cand.
  - out_margin = best - second, registered together with out_value.
  - Ties give margin 0.
- Undefined: no second-best logic; out_margin is tied to 0.

Test Plan (defaults: CATEGORIES=10, BITS_PER_CATEGORY=255, CHUNK_W=64, so BEATS=4, last-beat mask 63 bits):
- All categories zero, category 3 all ones -> out_valid 1 cycle after beat 40; out_index=3, out_value=255.
- Only category 0 last beat = 64'hFFFF_FFFF_FFFF_FFFF -> out_index=0, out_value=63 (bit 63 masked).
- Categories 2 and 7 each score 100, others 40 -> out_index=2, out_value=100; with MARGIN_EN out_margin=0.
- Category 9 = 200, category 4 = 150 -> out_index=9, out_value=200; out_margin=50 with LGN_ARGMAX_MARGIN_EN, 0 without.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid/out_index/out_value stable and in_ready=0. Release -> in_ready=1 next cycle, next frame result correct.
- clear pulsed with in_valid after 17 beats, then full frame with category 5 = 10 and others 0 -> out_index=5, out_value=10. Repeat with rst_n low mid-frame -> all outputs 0, same next-frame result.
